// File: rtl/div_pkg.sv
// Shared definitions for the divider-result BCD converter.
// Holds the FSM state encoding, the default iteration count and the
// operand / remainder / magnitude / BCD widths used by div_result_bcd.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEPS_DEFAULT = 5;  // shift/add-3 iterations = magnitude width
  localparam int Q_W           = 4;  // divider quotient width
  localparam int R_W           = 5;  // divider remainder width (two's complement)
  localparam int MAG_W         = 5;  // unsigned magnitude width of either operand
  localparam int BCD_W         = 8;  // two BCD digits: [7:4] tens, [3:0] ones
  localparam int SR_W          = BCD_W + MAG_W;  // {digits, operand} shift register

endpackage : div_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction.
// Ports:
//   digit     - 4-bit BCD digit before the shift
//   digit_adj - digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] digit_adj
);

  // Only digits 0..9 reach this block, so the +3 never wraps.
  assign digit_adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule : bcd_add3

// File: rtl/div_result_bcd.sv
// Converts a divider result (4-bit unsigned quotient, 5-bit two's-complement
// remainder) into two-digit BCD, one double-dabble step per cycle for both
// operands in parallel.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   q, r       - quotient / remainder from the divider
//   in_valid   - q/r valid;            in_ready  - block is IDLE and can accept
//   q_bcd      - quotient BCD;         r_bcd     - |r| BCD
//   r_neg      - captured r was negative
//   out_valid  - result valid (DONE);  out_ready - consumer takes the result
module div_result_bcd
  import div_pkg::*;
#(
  parameter int STEPS = STEPS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Q_W-1:0]   q,
  input  logic [R_W-1:0]   r,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BCD_W-1:0] q_bcd,
  output logic [BCD_W-1:0] r_bcd,
  output logic             r_neg,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  step_cnt;
  logic [SR_W-1:0]   q_sr;
  logic [SR_W-1:0]   r_sr;
  logic [SR_W-1:0]   q_corr;
  logic [SR_W-1:0]   r_corr;
  logic [SR_W-1:0]   q_sr_next;
  logic [SR_W-1:0]   r_sr_next;
  logic [R_W-1:0]    r_mag;
  logic [3:0]        q_tens_adj;
  logic [3:0]        q_ones_adj;
  logic [3:0]        r_tens_adj;
  logic [3:0]        r_ones_adj;
  logic              accept;
  logic              last_step;
  logic              handshake;

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == CONV) && (step_cnt == CNT_W'(STEPS - 1));
  assign handshake = (state == DONE) && out_ready;

  // -16 (5'b10000) negates to itself; read as unsigned that is the correct 16.
  assign r_mag = r[R_W-1] ? (~r + 5'd1) : r;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = CONV;
      CONV:    if (last_step) state_next = DONE;
      DONE:    if (handshake) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------- datapath
  bcd_add3 u_q_ones (.digit(q_sr[MAG_W+3:MAG_W]),   .digit_adj(q_ones_adj));
  bcd_add3 u_q_tens (.digit(q_sr[MAG_W+7:MAG_W+4]), .digit_adj(q_tens_adj));
  bcd_add3 u_r_ones (.digit(r_sr[MAG_W+3:MAG_W]),   .digit_adj(r_ones_adj));
  bcd_add3 u_r_tens (.digit(r_sr[MAG_W+7:MAG_W+4]), .digit_adj(r_tens_adj));

  // Correct the digits first, then shift the whole {digits, operand} word.
  assign q_corr    = {q_tens_adj, q_ones_adj, q_sr[MAG_W-1:0]};
  assign r_corr    = {r_tens_adj, r_ones_adj, r_sr[MAG_W-1:0]};
  assign q_sr_next = q_corr << 1;
  assign r_sr_next = r_corr << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sr     <= '0;
      r_sr     <= '0;
      step_cnt <= '0;
      q_bcd    <= '0;
      r_bcd    <= '0;
      r_neg    <= 1'b0;
    end else if (accept) begin
      q_sr     <= SR_W'({1'b0, q});
      r_sr     <= SR_W'(r_mag);
      step_cnt <= '0;
      q_bcd    <= '0;
      r_bcd    <= '0;
      r_neg    <= r[R_W-1];
    end else if (state == CONV) begin
      q_sr     <= q_sr_next;
      r_sr     <= r_sr_next;
      step_cnt <= step_cnt + 1'b1;
      // Outputs are only updated with the finished digits, so they hold the
      // previous result (or zero after an accept) while converting.
      if (last_step) begin
        q_bcd <= q_sr_next[SR_W-1:MAG_W];
        r_bcd <= r_sr_next[SR_W-1:MAG_W];
      end
    end
  end

endmodule : div_result_bcd

// File: tb/tb_div_result_bcd.sv
// Self-checking bench for div_result_bcd: directed vector table, hand-written
// backpressure and reset-abort sequences, and a full q/r sweep with random
// out_ready against a decimal reference model.
module tb_div_result_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] q_in;
  logic [4:0] r_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] q_bcd;
  logic [7:0] r_bcd;
  logic       r_neg;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  div_result_bcd #(.STEPS(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .q         (q_in),
    .r         (r_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
    .r_neg     (r_neg),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [4:0] r;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_neg;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: value -> two BCD digits.
  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // {r_neg, q_bcd, r_bcd} from the arithmetic meaning of q and r.
  function automatic logic [16:0] ref_result(input int qv, input int rv);
    int  rs;
    int  mag;
    logic neg;
    rs  = (rv >= 16) ? rv - 32 : rv;
    neg = (rs < 0);
    mag = neg ? -rs : rs;
    return {neg, to_bcd(qv), to_bcd(mag)};
  endfunction

  task automatic wait_ready(input string name);
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Full transaction: accept, measure latency, check result, hand it off.
  task automatic run_item(input string name, input logic [3:0] qv, input logic [4:0] rv,
                          input logic [7:0] eq, input logic [7:0] er, input logic en);
    int lat;
    wait_ready(name);
    q_in = qv; r_in = rv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, "_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd5);
    check({name, "_result"}, 32'({r_neg, q_bcd, r_bcd}), 32'({en, eq, er}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_handoff"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    int         accepts;
    int         results;
    int         t;
    bit         done;
    bit         was_valid;
    bit         rdy;
    logic [16:0] model_q[$];
    logic [16:0] exp_res;

    vecs[0] = '{4'd13, 5'b00010, 8'h13, 8'h02, 1'b0};
    vecs[1] = '{4'd15, 5'b10000, 8'h15, 8'h16, 1'b1};
    vecs[2] = '{4'd0,  5'b11101, 8'h00, 8'h03, 1'b1};
    vecs[3] = '{4'd9,  5'b01111, 8'h09, 8'h15, 1'b0};
    vecs[4] = '{4'd10, 5'b11111, 8'h10, 8'h01, 1'b1};
    vecs[5] = '{4'd7,  5'b10001, 8'h07, 8'h15, 1'b1};
    vecs[6] = '{4'd0,  5'b00000, 8'h00, 8'h00, 1'b0};

    rst = 1'b1; q_in = '0; r_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    check("reset_outputs", 32'({in_ready, out_valid, r_neg, q_bcd, r_bcd}),
          32'({1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
    step();
    step();
    rst = 1'b0;

    // ---------------- directed vector table
    foreach (vecs[i])
      run_item($sformatf("vec%0d", i), vecs[i].q, vecs[i].r,
               vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_neg);

    // ---------------- backpressure with competing in_valid
    wait_ready("bp");
    q_in = 4'd5; r_in = 5'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    check("bp_first", 32'({r_neg, q_bcd, r_bcd}), 32'({1'b0, 8'h05, 8'h04}));
    q_in = 4'd12; r_in = 5'd7; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bp_hold%0d", c),
            32'({out_valid, in_ready, r_neg, q_bcd, r_bcd}),
            32'({1'b1, 1'b0, 1'b0, 8'h05, 8'h04}));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release", 32'({out_valid, in_ready, q_bcd, r_bcd}),
          32'({1'b0, 1'b1, 8'h05, 8'h04}));
    step();
    in_valid = 1'b0;
    check("bp_accept", 32'({in_ready, q_bcd, r_bcd}), 32'({1'b0, 8'h00, 8'h00}));
    t = 0;
    while (!out_valid && t < 50) begin step(); t++; end
    check("bp_latency", 32'(t), 32'd5);
    check("bp_second", 32'({r_neg, q_bcd, r_bcd}), 32'({1'b0, 8'h12, 8'h07}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // ---------------- reset abort on the 2nd CONV cycle
    wait_ready("abort");
    q_in = 4'd11; r_in = 5'b11000; in_valid = 1'b1;
    step();                         // accept edge: CONV cycle 1
    in_valid = 1'b0;
    check("abort_neg_captured", 32'(r_neg), 32'd1);
    step();                         // CONV cycle 2
    rst = 1'b1;
    #1;
    check("abort_outputs", 32'({in_ready, out_valid, r_neg, q_bcd, r_bcd}),
          32'({1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
    step();
    rst = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) done = 1'b1;
      step();
    end
    check("abort_no_result", 32'(done), 32'd0);
    run_item("after_abort", 4'd11, 5'b11000, 8'h11, 8'h08, 1'b1);

    // ---------------- sweep all q/r with random out_ready
    accepts = 0;
    results = 0;
    for (int qi = 0; qi < 16; qi++) begin
      for (int ri = 0; ri < 32; ri++) begin
        repeat ($urandom_range(0, 2)) step();
        wait_ready("sweep");
        q_in = 4'(qi); r_in = 5'(ri); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        model_q.push_back(ref_result(qi, ri));
        accepts++;
        done = 1'b0;
        t = 0;
        while (!done && t < 40) begin
          was_valid = out_valid;
          if (out_valid) begin
            exp_res = model_q[0];
            check($sformatf("sweep_q%0d_r%0d", qi, ri),
                  32'({r_neg, q_bcd, r_bcd}), 32'(exp_res));
          end
          rdy       = 1'($urandom_range(0, 1));
          out_ready = rdy;
          in_valid  = 1'($urandom_range(0, 1));
          q_in      = 4'($urandom);
          r_in      = 5'($urandom);
          step();
          in_valid = 1'b0;
          if (was_valid && rdy) begin
            void'(model_q.pop_front());
            results++;
            done = 1'b1;
          end
          t++;
        end
        out_ready = 1'b0;
        if (!done) check("sweep_timeout", 32'(done), 32'd1);
      end
    end
    check("sweep_count", 32'(results), 32'(accepts));
    check("sweep_count_total", 32'(results), 32'd512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_result_bcd

// File: doc/div_result_bcd.md
DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: q  input  4  unsigned quotient from the 4-bit non-restoring divider.
REQ-004 SHALL have ports: r  input  5  two's-complement remainder from the divider.
REQ-005 SHALL have ports: in_valid  input  1  q/r valid.
REQ-006 SHALL have ports: in_ready  output  1  block can accept q/r.
REQ-007 SHALL have ports: q_bcd  output  8  quotient BCD, [7:4] tens, [3:0] ones.
REQ-008 SHALL have ports: r_bcd  output  8  |r| BCD, [7:4] tens, [3:0] ones.
REQ-009 SHALL have ports: r_neg  output  1  captured r was negative.
REQ-010 SHALL have ports: out_valid  output  1  q_bcd/r_bcd/r_neg valid.
REQ-011 SHALL have ports: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have parameter: STEPS, default 5, number of shift/add-3 iterations (equals the magnitude width).

Function
REQ-013 SHALL implement FSM states IDLE, CONV, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-015 Accept on an edge with in_valid=1 in IDLE: capture {1'b0,q} and mag=(r[4] ? -r : r) as 5-bit unsigned; r_neg<=r[4]; clear digit registers; step counter<=0; go to CONV.
REQ-016 -r=16 (r=5'b10000) SHALL yield mag=16, not overflow.
REQ-017 Each CONV cycle SHALL perform one double-dabble step per operand: add 3 to any BCD digit >=5, then shift the {digits,operand} register left by 1.
REQ-018 After STEPS CONV cycles, the FSM SHALL enter DONE; out_valid SHALL go high exactly STEPS edges after the accept edge.
REQ-019 In DONE, q_bcd, r_bcd, r_neg SHALL be held stable until the handshake completes.
REQ-020 out_valid&out_ready in DONE SHALL cause a return to IDLE on that edge; no same-cycle re-accept; the earliest next accept is the following edge.
REQ-021 in_valid outside IDLE SHALL be ignored with no state change.
REQ-022 Outside DONE, out_valid SHALL be 0; q_bcd/r_bcd SHALL retain their last DONE values until the next accept clears them.
REQ-023 Throughput SHALL be at most one result per STEPS+2 cycles.

Reset
REQ-024 rst SHALL asynchronously force IDLE, in_ready=1, out_valid=0, q_bcd=0, r_bcd=0, r_neg=0, counter=0.
REQ-025 rst during CONV or DONE SHALL abort the conversion with no result emitted; the first accept is possible on the first edge after deassertion.

Structure
REQ-026 Shared package div_pkg SHALL hold: FSM state encoding, STEPS default, operand width 4, remainder width 5, BCD width 8.
REQ-027 Sub-module bcd_add3 (4-bit combinational digit correction, +3 if >=5) SHALL be instantiated per digit (4 instances).

Verification
REQ-028 q=13, r=5'b00010, in_valid pulse in IDLE -> out_valid high 5 edges later; q_bcd=8'h13, r_bcd=8'h02, r_neg=0.
REQ-029 q=4'd15, r=5'b10000 -> q_bcd=8'h15, r_bcd=8'h16, r_neg=1.
REQ-030 q=0, r=5'b11101 (-3) -> q_bcd=8'h00, r_bcd=8'h03, r_neg=1.
REQ-031 out_ready held 0 for 10 cycles in DONE while in_valid=1 with new data -> outputs unchanged, in_ready=0; after out_ready=1, in_ready=1 on the next cycle and new data is accepted the cycle after.
REQ-032 rst asserted on the 2nd CONV cycle -> immediate IDLE, all outputs 0, out_valid never asserted for the aborted item; the next item converts correctly.
REQ-033 Exhaustive sweep of all 16x32 q/r pairs with random out_ready -> every result matches the decimal reference model; the count of results equals the count of accepts.
